// File: rtl/uart_pkg.sv
// Shared UART definitions: line-state enum and width helpers.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Counter width for a modulus, never narrower than one bit
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: strobes pulse_done_o in the last cycle of each serial bit.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_PULSE = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic en_i,
    output logic pulse_done_o
);

    localparam int unsigned CNT_W = clog2_min1(CLOCKS_PER_PULSE);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLOCKS_PER_PULSE - 1);
    localparam logic [CNT_W-1:0] CNT_BEFORE = CNT_W'(CLOCKS_PER_PULSE - 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;

    // Count while enabled, wrap at the last cycle of a bit; strobe is
    // registered so it is raised one cycle ahead of the wrap.
    always_comb begin
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (!en_i || cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        pulse_d = en_i && (cnt_q == CNT_BEFORE);
    end

    // Counter and strobe registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_done_o = pulse_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: sends each parallel transaction as NUM_WORDS back-to-back 8N1-style frames.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_PULSE = 4,
    parameter int unsigned W_in             = 16,
    parameter int unsigned BITS_PER_WORD    = 8
) (
    input  logic                                          clk,
    input  logic                                          rstn,
    input  logic                                          s_valid,
    output logic                                          s_ready,
    input  logic [W_in/BITS_PER_WORD-1:0][BITS_PER_WORD-1:0] s_data,
    output logic                                          tx
);

    localparam int unsigned NUM_WORDS = W_in / BITS_PER_WORD;
    localparam int unsigned BIT_W     = clog2_min1(BITS_PER_WORD);
    localparam int unsigned WORD_W    = clog2_min1(NUM_WORDS);

    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BITS_PER_WORD - 1);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(NUM_WORDS - 1);

    typedef logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0] data_t;

    uart_state_e               state_q, state_d;
    data_t                     data_q, data_d;
    logic [BIT_W-1:0]          bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0]         word_cnt_q, word_cnt_d;
    logic                      tx_q, tx_d;
    logic                      s_ready_q, s_ready_d;
    logic                      pulse_done;
    logic [BITS_PER_WORD-1:0]  cur_word;
    logic [BIT_W-1:0]          next_bit;

    uart_baud_cnt #(
        .CLOCKS_PER_PULSE(CLOCKS_PER_PULSE)
    ) u_baud_cnt (
        .clk         (clk),
        .rstn        (rstn),
        .en_i        (state_q != IDLE),
        .pulse_done_o(pulse_done)
    );

    assign cur_word = data_q[word_cnt_q];
    assign next_bit = bit_cnt_q + BIT_W'(1);

    // Next state; tx is computed for the state being entered so it is registered
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        tx_d       = tx_q;
        s_ready_d  = s_ready_q;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (s_valid) begin
                    state_d    = START;
                    data_d     = s_data;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    tx_d       = 1'b0;
                end
            end
            START: begin
                if (pulse_done) begin
                    state_d = DATA;
                    tx_d    = cur_word[bit_cnt_q];
                end
            end
            DATA: begin
                if (pulse_done) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_cnt_d = next_bit;
                        tx_d      = cur_word[next_bit];
                    end
                end
            end
            STOP: begin
                if (pulse_done) begin
                    if (word_cnt_q == WORD_LAST) begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end else begin
                        state_d    = START;
                        word_cnt_d = word_cnt_q + WORD_W'(1);
                        bit_cnt_d  = '0;
                        tx_d       = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        s_ready_d = (state_d == IDLE);
    end

    // State, data and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            data_q     <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            tx_q       <= 1'b1;
            s_ready_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            tx_q       <= tx_d;
            s_ready_q  <= s_ready_d;
        end
    end

    assign tx      = tx_q;
    assign s_ready = s_ready_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: per-cycle line model plus a frame decoder feeding a transaction scoreboard.
module tb_uart_tx;

    localparam int CPP   = 4;
    localparam int W     = 16;
    localparam int BPW   = 8;
    localparam int NW    = W / BPW;
    localparam int FRAME = BPW + 2;
    localparam int BUSY  = NW * FRAME * CPP;

    logic         clk;
    logic         rstn;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_data;
    logic         tx;

    logic         s_valid2;
    logic         s_ready2;
    logic [7:0]   s_data2;
    logic         tx2;

    int checks = 0;
    int errors = 0;
    int accepts = 0;

    bit           exp_q[$];
    logic [W-1:0] txn_q[$];
    bit           model_ready = 1'b1;
    int           lowrun = 0;

    uart_tx #(
        .CLOCKS_PER_PULSE(CPP),
        .W_in(W),
        .BITS_PER_WORD(BPW)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data (s_data),
        .tx     (tx)
    );

    uart_tx #(
        .CLOCKS_PER_PULSE(2),
        .W_in(8),
        .BITS_PER_WORD(8)
    ) dut2 (
        .clk    (clk),
        .rstn   (rstn),
        .s_valid(s_valid2),
        .s_ready(s_ready2),
        .s_data (s_data2),
        .tx     (tx2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected line waveform of one transaction, one entry per clock cycle
    function automatic void push_frames(input logic [W-1:0] d);
        for (int w = 0; w < NW; w++) begin
            for (int b = 0; b < FRAME; b++) begin
                bit v;
                if (b == 0)              v = 1'b0;
                else if (b == FRAME - 1) v = 1'b1;
                else                     v = d[w*BPW + b - 1];
                for (int c = 0; c < CPP; c++) exp_q.push_back(v);
            end
        end
    endfunction

    // Stimulus side of the scoreboard: record every accepted transaction
    always @(posedge clk) begin
        if (rstn && s_valid && model_ready) begin
            push_frames(s_data);
            txn_q.push_back(s_data);
            accepts++;
        end
    end

    // Cycle monitor: line level, ready, and busy-window length
    always @(negedge clk) begin
        bit etx;
        bit erdy;
        if (!rstn) begin
            exp_q.delete();
            etx    = 1'b1;
            erdy   = 1'b1;
            lowrun = 0;
        end else begin
            erdy = (exp_q.size() == 0);
            etx  = erdy ? 1'b1 : exp_q.pop_front();
            if (!s_ready) begin
                lowrun++;
            end else begin
                if (lowrun != 0) check("busy_len", 32'(lowrun), 32'(BUSY));
                lowrun = 0;
            end
        end
        model_ready = erdy;
        check("tx", 32'(tx), 32'(etx));
        check("s_ready", 32'(s_ready), 32'(erdy));
    end

    // Frame decoder: rebuilds transactions from tx and compares with the scoreboard
    int           dcyc = 0;
    bit           dactive = 1'b0;
    int           dword = 0;
    logic [W-1:0] dacc;
    logic [BPW-1:0] dbits;

    always @(negedge clk) begin
        if (!rstn) begin
            dactive = 1'b0;
            dword   = 0;
            txn_q.delete();
        end else begin
            if (!dactive) begin
                if (tx == 1'b0) begin
                    dactive = 1'b1;
                    dcyc    = 0;
                end
            end else begin
                dcyc++;
            end
            if (dactive && (dcyc % CPP) == CPP / 2) begin
                int bi;
                bi = dcyc / CPP;
                if (bi == 0) begin
                    check("start_bit", 32'(tx), 32'(0));
                end else if (bi <= BPW) begin
                    dbits[bi-1] = tx;
                end else begin
                    check("stop_bit", 32'(tx), 32'(1));
                    dacc[dword*BPW +: BPW] = dbits;
                    dword++;
                    dactive = 1'b0;
                    if (dword == NW) begin
                        dword = 0;
                        check("txn_pending", 32'(txn_q.size() != 0), 32'(1));
                        if (txn_q.size() != 0) check("rx_data", 32'(dacc), 32'(txn_q.pop_front()));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Offer d until accepted; optionally leave s_valid high afterwards
    task automatic send(input logic [W-1:0] d, input bit keep);
        int n;
        bit ok;
        n       = accepts;
        ok      = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (accepts != n) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept_bound", 32'(ok), 32'(1));
        if (!keep) s_valid = 1'b0;
    endtask

    // Let the line drain, scrambling s_data meanwhile
    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            s_data = W'($urandom);
            if (model_ready && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_bound", 32'(ok), 32'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] pat;
        rstn     = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        s_valid2 = 1'b0;
        s_data2  = '0;
        repeat (3) tick();
        rstn = 1'b1;
        repeat (2) tick();

        // Single transaction with a known pattern
        send(16'hA53C, 1'b0);
        wait_idle();
        repeat (3) tick();

        // Back-to-back with s_valid held; s_data changes during the first one
        send(16'h00FF, 1'b1);
        s_data = 16'hFF00;
        send(16'hFF00, 1'b0);
        wait_idle();
        repeat (2) tick();

        // Reset during the third data bit of word 0
        send(W'($urandom), 1'b0);
        repeat (13) tick();
        rstn = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        repeat (6) tick();

        // Random transactions with random gaps
        for (int t = 0; t < 100; t++) begin
            int gap;
            gap = int'($urandom_range(1, 20));
            send(W'($urandom), 1'b0);
            for (int g = 0; g < gap; g++) begin
                tick();
                s_data = W'($urandom);
            end
        end
        wait_idle();
        repeat (5) tick();
        check("txn_q_drained", 32'(txn_q.size()), 32'(0));

        // Narrow configuration: one word, two cycles per bit
        pat = 10'b1100000010;
        @(negedge clk);
        check("n1_idle_tx", 32'(tx2), 32'(1));
        check("n1_idle_ready", 32'(s_ready2), 32'(1));
        tick();
        s_data2  = 8'h81;
        s_valid2 = 1'b1;
        tick();
        s_valid2 = 1'b0;
        s_data2  = 8'h7E;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("n1_tx", 32'(tx2), 32'(pat[i/2]));
            check("n1_busy_ready", 32'(s_ready2), 32'(0));
        end
        @(negedge clk);
        check("n1_end_tx", 32'(tx2), 32'(1));
        check("n1_end_ready", 32'(s_ready2), 32'(1));
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
